// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the ALU and the load unit,
// with one registered write stage and a busy scoreboard for decode hazard checks.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_AW     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [REG_AW-1:0]      req0_reg,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [REG_AW-1:0]      req1_reg,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    input  logic                   issue_en,
    input  logic [REG_AW-1:0]      issue_reg,
    input  logic [REG_AW-1:0]      chk_reg_a,
    input  logic [REG_AW-1:0]      chk_reg_b,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [2**REG_AW-1:0]   busy_vec,
    output logic                   sb_err,
    output logic                   write_en,
    output logic [REG_AW-1:0]      write_reg,
    output logic [DATA_WIDTH-1:0]  write_data
);

    logic                  last;
    logic                  grant0;
    logic                  grant1;
    logic                  grant_any;
    logic [REG_AW-1:0]     sel_reg_p0;
    logic [DATA_WIDTH-1:0] sel_data_p0;
    logic                  vld_p0;
    logic                  issue_live;
    logic [2**REG_AW-1:0]  busy_nxt;

    // Stage 0: arbitration; last holds the index of the most recently granted requester.
    always_comb begin
        grant0      = !rst && req0_valid && (!req1_valid || last);
        grant1      = !rst && req1_valid && (!req0_valid || !last);
        grant_any   = grant0 || grant1;
        sel_reg_p0  = grant1 ? req1_reg  : req0_reg;
        sel_data_p0 = grant1 ? req1_data : req0_data;
        vld_p0      = grant_any && (sel_reg_p0 != '0);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Stage 1: write stage; a reg-0 grant is consumed without producing a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (grant_any) begin
                last <= grant1;
            end
            write_en <= vld_p0;
            if (vld_p0) begin
                write_reg  <= sel_reg_p0;
                write_data <= sel_data_p0;
            end
        end
    end

    assign issue_live = issue_en && (issue_reg != '0);

    // Set is applied after clear so an issue on the commit edge keeps the bit busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (write_en) begin
            busy_nxt[write_reg] = 1'b0;
        end
        if (issue_live) begin
            busy_nxt[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            sb_err   <= issue_live && busy_vec[issue_reg];
        end
    end

    assign busy_a = busy_vec[chk_reg_a];
    assign busy_b = busy_vec[chk_reg_b];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations, then
// random traffic, all cross-checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AW-1:0] req0_reg, req1_reg, issue_reg, chk_reg_a, chk_reg_b, write_reg;
    logic [DW-1:0] req0_data, req1_data, write_data;
    logic          issue_en, busy_a, busy_b, sb_err, write_en;
    logic [31:0]   busy_vec;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .issue_en(issue_en), .issue_reg(issue_reg), .chk_reg_a(chk_reg_a), .chk_reg_b(chk_reg_b),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec), .sb_err(sb_err),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: m_last is the index of the requester granted most recently.
    int          m_last = 1,  n_last = 1;
    logic        m_we = 0,    n_we = 0;
    logic [4:0]  m_wreg = 0,  n_wreg = 0;
    logic [63:0] m_wdata = 0, n_wdata = 0;
    logic        m_wknown = 1, n_wknown = 1;
    logic [31:0] m_busy = 0,  n_busy = 0;
    logic        m_err = 0,   n_err = 0;
    bit          started = 0;
    logic        e0, e1, s0, s1;
    int          w;

    always @(negedge clk) begin
        e0 = !rst && req0_valid && (!req1_valid || m_last != 0);
        e1 = !rst && req1_valid && (!req0_valid || m_last != 1);
        s0 = req0_ready;
        s1 = req1_ready;
        if (started) begin
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("write_en", write_en, m_we);
            if (m_wknown) begin
                chk("write_reg", write_reg, m_wreg);
                chk("write_data", write_data, m_wdata);
            end
            chk("busy_vec", busy_vec, m_busy);
            chk("busy_a", busy_a, m_busy[chk_reg_a]);
            chk("busy_b", busy_b, m_busy[chk_reg_b]);
            chk("sb_err", sb_err, m_err);
        end
        n_last = m_last; n_wreg = m_wreg; n_wdata = m_wdata; n_wknown = m_wknown;
        n_busy = m_busy; n_we = 0; n_err = 0;
        if (rst) begin
            n_last = 1; n_wreg = 0; n_wdata = 0; n_wknown = 1; n_busy = 0;
        end else begin
            if (e0 || e1) begin
                w = e0 ? 0 : 1;
                n_last = w;
                if ((w == 0 ? req0_reg : req1_reg) != 0) begin
                    n_we = 1;
                    n_wreg = (w == 0) ? req0_reg : req1_reg;
                    n_wdata = (w == 0) ? req0_data : req1_data;
                    n_wknown = 1;
                end else begin
                    n_wknown = 0;
                end
            end
            if (m_we) n_busy[m_wreg] = 1'b0;
            if (issue_en && issue_reg != 0) begin
                n_err = m_busy[issue_reg];
                n_busy[issue_reg] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        m_last = n_last; m_we = n_we; m_wreg = n_wreg; m_wdata = n_wdata;
        m_wknown = n_wknown; m_busy = n_busy; m_err = n_err;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0; req0_reg = 0; req1_reg = 0;
        req0_data = 0; req1_data = 0; issue_en = 0; issue_reg = 0; chk_reg_a = 0; chk_reg_b = 0;
        repeat (2) cyc();
        started = 1;

        // Reset state and single ALU write
        req0_valid = 1; req0_reg = 5; req0_data = 64'hAA;
        neg();
        chk("rst_write_en", write_en, 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_req0_ready", req0_ready, 0);
        cyc(); rst = 0;
        neg(); chk("t1_ready", req0_ready, 1);
        cyc(); req0_valid = 0;
        neg();
        chk("t1_we", write_en, 1);
        chk("t1_reg", write_reg, 5);
        chk("t1_data", write_data, 64'hAA);

        // Round-robin with both requesters valid, starting from reset
        cyc(); rst = 1;
        cyc(); rst = 0;
        req0_valid = 1; req0_reg = 1; req0_data = 64'h11;
        req1_valid = 1; req1_reg = 2; req1_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("t2_ready0", req0_ready, (i % 2 == 0));
            chk("t2_ready1", req1_ready, (i % 2 == 1));
            if (i > 0) chk("t2_wreg", write_reg, ((i - 1) % 2 == 0) ? 1 : 2);
            cyc();
        end
        req0_valid = 0; req1_valid = 0;
        neg();
        chk("t2_we_last", write_en, 1);
        chk("t2_wreg_last", write_reg, 2);

        // Issue sets busy, load write clears it
        cyc(); issue_en = 1; issue_reg = 7;
        cyc(); issue_en = 0; chk_reg_a = 7;
        req1_valid = 1; req1_reg = 7; req1_data = 64'h77;
        neg();
        chk("t3_busy7", busy_vec[7], 1);
        chk("t3_busy_a", busy_a, 1);
        chk("t3_ready1", req1_ready, 1);
        cyc(); req1_valid = 0;
        neg();
        chk("t3_we", write_en, 1);
        chk("t3_wreg", write_reg, 7);
        chk("t3_busy_a_nobypass", busy_a, 1);
        cyc();
        neg();
        chk("t3_busy7_clr", busy_vec[7], 0);

        // Set wins over clear on the same edge, then a WAW issue flags sb_err
        req0_valid = 1; req0_reg = 9; req0_data = 64'h99;
        cyc(); req0_valid = 0; issue_en = 1; issue_reg = 9;
        neg(); chk("t4_we", write_en, 1); chk("t4_wreg", write_reg, 9);
        cyc();
        neg(); chk("t4_busy9", busy_vec[9], 1); chk("t4_err0", sb_err, 0);
        cyc(); issue_en = 0;
        neg(); chk("t4_err1", sb_err, 1);
        cyc();
        neg(); chk("t4_err_pulse", sb_err, 0);

        // Write to register 0 completes but does not write
        req0_valid = 1; req0_reg = 0; req0_data = 64'hFF; chk_reg_a = 0;
        neg(); chk("t5_ready", req0_ready, 1); chk("t5_busy_a", busy_a, 0);
        cyc(); req0_valid = 0;
        neg(); chk("t5_we", write_en, 0); chk("t5_busy", busy_vec, 32'h200);

        // Reset while the load unit requests
        req1_valid = 1; req1_reg = 3; req1_data = 64'h33; rst = 1;
        neg(); chk("t6_ready_rst", req1_ready, 0);
        cyc(); rst = 0;
        neg();
        chk("t6_we", write_en, 0);
        chk("t6_busy", busy_vec, 0);
        chk("t6_ready_re", req1_ready, 1);
        cyc(); req1_valid = 0;
        neg(); chk("t6_we_re", write_en, 1); chk("t6_wreg_re", write_reg, 3);

        // Random traffic; a requester only moves on after its handshake
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (s0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_reg = AW'($urandom_range(0, 31));
                req0_data = {$urandom, $urandom};
            end
            if (s1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_reg = AW'($urandom_range(0, 31));
                req1_data = {$urandom, $urandom};
            end
            issue_en = ($urandom_range(0, 3) == 0);
            issue_reg = AW'($urandom_range(0, 31));
            chk_reg_a = AW'($urandom_range(0, 31));
            chk_reg_b = AW'($urandom_range(0, 31));
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 0;
        neg();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
